operand_stream_ctrl: RTL
========================

// Module: operand_stream_ctrl
// PURPOSE
//  Parametrised successor to the BRAM operand controller. Walks operand memory from address 0 to LAST_ADDR
//  and splits each word into signed A/B operands. Presents them to the Dadda multiplier on a valid/ready
//  handshake. Handles BRAM read latency and multiplier backpressure via a credit-limited skid FIFO;
//  supports pause/resume, single-pass and looping modes.
// PARAMETERS
//  DATA_W   16  operand width; douta carries {B,A}, 2*DATA_W bits
//  ADDR_W   4   BRAM address width
//  RD_LAT   1   BRAM read latency in cycles (1..3), ena-to-douta
//  FIFO_D   4   skid FIFO depth; must be >= RD_LAT+1
// PORTS
//  clka       in   1         clock; one clock domain
//  rst        in   1         reset; synchronous, active-high
//  start_stop in   1         level: 1 = run/resume, 0 = pause
//  loop_en    in   1         1 = wrap LAST_ADDR->0 and continue; 0 = single pass then DONE
//  last_addr  in   ADDR_W    final address of pass; sampled on IDLE->RUN only
//  douta      in   2*DATA_W  BRAM read data, valid RD_LAT cycles after ena
//  addra      out  ADDR_W    BRAM address
//  ena        out  1         BRAM read enable (one read per asserted cycle)
//  a, b       out  DATA_W    signed operands: a=douta[DATA_W-1:0], b=douta[2*DATA_W-1:DATA_W]
//  op_valid   out  1         a/b valid
//  op_ready   in   1         multiplier accepts; transfer when op_valid&&op_ready
//  busy       out  1         state != IDLE
//  done       out  1         one-cycle pulse on the final transfer of a single pass
//  pair_cnt   out  16        transfers since last IDLE->RUN, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: addra=0, ena=0, a=b=0, op_valid=0, busy=0, done=0, pair_cnt=0, FIFO empty, in-flight cleared, state IDLE.
//  rst mid-operation: in-flight reads discarded (returning douta ignored) and FIFO flushed.
//  FSM states: IDLE, RUN, PAUSE, DRAIN.
//   IDLE : start_stop=1 -> RUN; addra<=0, pair_cnt<=0, last_addr latched.
//   RUN  : issue read if credits ok; start_stop=0 -> PAUSE; last_addr issued && !loop_en -> DRAIN.
//   PAUSE: no new reads; in-flight data still lands in FIFO and drains; start_stop=1 -> RUN at next addra.
//   DRAIN: no new reads; FIFO empty && in-flight=0 -> IDLE; done pulses with last transfer.
//  Issue rule: ena=1 iff state RUN && (fifo_count + in_flight) < FIFO_D; addra post-increments after issue.
//   At addra==last_addr: loop_en=1 -> addra<=0; else enter DRAIN. Never drop data or overflow FIFO.
//  Capture: RD_LAT-deep valid shift register tracks in-flight reads; douta pushed on tap-out.
//  Output: a/b/op_valid from FIFO head. op_valid stays asserted and a/b stay stable until op_ready.
//   Push and pop in the same cycle are both honoured; count is unchanged.
//  Throughput: one pair per cycle when op_ready held high; first op_valid RD_LAT+1 cycles after first ena.
//  last_addr=0: single pair per pass. loop_en changes in RUN take effect at the next last_addr.
//  done: single-pass only, never in loop mode. Not pulsed when a pass is left by reset.
//  pair_cnt: increments per transfer and holds through PAUSE.
// STRUCTURE
//  Package mul_ctrl_pkg holds: state enum (IDLE/RUN/PAUSE/DRAIN), DATA_W/ADDR_W defaults, operand-pair typedef.
//  One sub-module, op_skid_fifo: sync FIFO with params WIDTH=2*DATA_W, DEPTH=FIFO_D; provides count/full/empty.
//   Same-cycle push+pop allowed.
//  Top level holds FSM, address counter, in-flight shift register and credit check.
// TESTING (bench BRAM model with configurable RD_LAT; word k = {16'(-k), 16'(k+1)})
//  1 last_addr=3, loop_en=0, ready=1, RD_LAT=1 -> pairs (1,-0)..(4,-3) on 4 consecutive cycles,
//    done on 4th, busy drops next cycle.
//  2 RD_LAT=2, op_ready toggling 1010.. -> all 16 pairs in order, none lost or duplicated,
//    FIFO count <= FIFO_D, a/b stable while stalled.
//  3 start_stop low after 5 issues for 10 cycles -> in-flight pairs drain, ena=0 during pause;
//    resume continues at addr 5; pair_cnt=16 at end.
//  4 loop_en=1, last_addr=2, run 9 transfers -> addra sequence 0,1,2,0,1,2..; no done pulse.
//  5 rst asserted with 2 in flight and FIFO non-empty -> next cycle all outputs at reset values,
//    late douta ignored.
//  6 last_addr=0, single pass -> exactly one transfer with done on it.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared types for the operand stream controller: FSM state encoding,
// default operand/address widths and the packed {B,A} operand-pair layout.
package mul_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DRAIN
    } state_e;

    // Matches the BRAM word layout: B in the upper half, A in the lower.
    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] b;
        logic signed [DATA_W_DEF-1:0] a;
    } op_pair_t;

endpackage

// File: rtl/operand_stream_ctrl_if.sv
// Operand handshake towards the multiplier: signed a/b with op_valid/op_ready.
// master = operand source (controller), slave = operand sink (multiplier).
interface operand_stream_ctrl_if #(
    parameter int DATA_W = 16
) ();

    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic                     op_valid;
    logic                     op_ready;

    modport master (
        output a,
        output b,
        output op_valid,
        input  op_ready
    );

    modport slave (
        input  a,
        input  b,
        input  op_valid,
        output op_ready
    );

endinterface

// File: rtl/op_skid_fifo.sv
// Synchronous skid FIFO; same-cycle push and pop are both honoured.
// Ports: clk/rst, push/din, pop/dout (head), count/full/empty status.
module op_skid_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign count = cnt_q;
    assign dout  = mem_q[rd_q];

    always_comb begin
        do_pop  = pop && !empty;
        // When full, a simultaneous pop frees the slot being written.
        do_push = push && (!full || do_pop);
        wr_d    = do_push ? nxt(wr_q) : wr_q;
        rd_d    = do_pop ? nxt(rd_q) : rd_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/operand_stream_ctrl.sv
// Walks operand BRAM 0..last_addr, splits each word into signed A/B and
// streams them to the multiplier through a credit-limited skid FIFO.
// Ports: clka/rst, start_stop, loop_en, last_addr, BRAM addra/ena/douta,
// op (a/b/op_valid/op_ready), busy, done, pair_cnt.
module operand_stream_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = 1,
    parameter int FIFO_D = 4
) (
    input  logic                    clka,
    input  logic                    rst,
    input  logic                    start_stop,
    input  logic                    loop_en,
    input  logic [ADDR_W-1:0]       last_addr,
    input  logic [2*DATA_W-1:0]     douta,
    output logic [ADDR_W-1:0]       addra,
    output logic                    ena,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             pair_cnt,
    operand_stream_ctrl_if.master   op
);

    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam int FLT_W = $clog2(RD_LAT + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [FLT_W-1:0]    in_flight;
    logic [2*DATA_W-1:0] head;
    logic                fifo_full, fifo_empty;
    logic                issue, xfer, at_last, last_pop;

    op_skid_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk   (clka),
        .rst   (rst),
        .push  (vld_q[RD_LAT-1]),
        .din   (douta),
        .pop   (xfer),
        .dout  (head),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + FLT_W'(vld_q[i]);
        end
    end

    // A read may only be issued if its data is guaranteed a FIFO slot.
    assign issue = (state_q == RUN) && !fifo_full &&
                   (int'(fifo_cnt) + int'(in_flight) < FIFO_D);
    assign xfer    = !fifo_empty && op.op_ready;
    assign at_last = (addra_q == last_q);
    assign vld_d   = RD_LAT'({vld_q, issue});

    // Final pop of a pass: nothing in flight and this is the last entry.
    assign last_pop = (vld_q == '0) && (fifo_cnt == CNT_W'(1)) && xfer;

    always_comb begin
        state_d = state_q;
        addra_d = addra_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (xfer && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (start_stop) begin
                    state_d = RUN;
                    addra_d = '0;
                    cnt_d   = '0;
                    last_d  = last_addr;
                end
            end
            RUN: begin
                if (issue) begin
                    addra_d = at_last ? '0 : addra_q + ADDR_W'(1);
                end
                if (issue && at_last && !loop_en) begin
                    state_d = DRAIN;
                end else if (!start_stop) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (start_stop) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if ((vld_q == '0 && fifo_empty) || last_pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q <= IDLE;
            addra_q <= '0;
            last_q  <= '0;
            vld_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addra_q <= addra_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ena         = issue;
    assign addra       = addra_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DRAIN) && last_pop;
    assign pair_cnt    = cnt_q;
    assign op.op_valid = !fifo_empty;
    assign op.a        = fifo_empty ? '0 : head[DATA_W-1:0];
    assign op.b        = fifo_empty ? '0 : head[2*DATA_W-1:DATA_W];

endmodule
